// File: rtl/router_fifo_if.sv
// Handshake bundle between the router datapath/destination and one output FIFO.
// master drives requests and data; slave is the FIFO itself.
interface router_fifo_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic              write_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic [AW:0]       fill;
  logic              pkt_active;
  logic              pkt_done;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, full, empty, fill, pkt_active, pkt_done
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, full, empty, fill, pkt_active, pkt_done
  );
endinterface

// File: rtl/router_fifo.sv
// Output-side packet FIFO of router 1x3: stores {hdr_flag, byte} entries,
// drains them under read_enb and tracks the remaining bytes of a packet.
module router_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        soft_reset,
  router_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [6:0]        pkt_cnt;
  logic [DATA_W-1:0] dout;
  logic              done;
  logic              full;
  logic              empty;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W:0]   rd_entry;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_fire  = bus.write_enb & ~full;
  assign rd_fire  = bus.read_enb & ~empty;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (wr_fire && !soft_reset)
      mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
      dout    <= '0;
      done    <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
      dout    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_fire)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout   <= rd_entry[DATA_W-1:0];
        // A header always reloads, even mid-packet.
        if (rd_entry[DATA_W]) begin
          pkt_cnt <= {1'b0, rd_entry[7:2]} + 7'd1;
        end else if (pkt_cnt != 7'd0) begin
          pkt_cnt <= pkt_cnt - 7'd1;
          done    <= (pkt_cnt == 7'd1);
        end
      end
    end
  end

  assign bus.data_out   = dout;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.fill       = wr_ptr - rd_ptr;
  assign bus.pkt_active = (pkt_cnt != 7'd0);
  assign bus.pkt_done   = done;
endmodule

// File: tb/tb_router_fifo.sv
// Bench for router_fifo: directed steps plus random traffic,
// each checked against a queue-based packet model.
module tb_router_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic clock      = 1'b0;
  logic resetn     = 1'b0;
  logic soft_reset = 1'b0;

  router_fifo_if #(.DEPTH(DEPTH), .DATA_W(DW)) bus ();

  router_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] q[$];
  logic [7:0] m_dout = 8'h00;
  int         m_rem  = 0;
  logic       m_done = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_dout = 8'h00;
    m_rem  = 0;
    m_done = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_dout"},   32'(bus.data_out),   32'(m_dout));
    check({tag, "_full"},   32'(bus.full),       32'(q.size() == DEPTH));
    check({tag, "_empty"},  32'(bus.empty),      32'(q.size() == 0));
    check({tag, "_fill"},   32'(bus.fill),       32'(q.size()));
    check({tag, "_active"}, 32'(bus.pkt_active), 32'(m_rem != 0));
    check({tag, "_done"},   32'(bus.pkt_done),   32'(m_done));
  endtask

  task automatic cycle(input logic we, input logic lfd,
                       input logic [7:0] din, input logic re,
                       input logic sr, input string tag);
    logic       wok;
    logic       rok;
    logic [8:0] e;
    bus.write_enb = we;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    bus.read_enb  = re;
    soft_reset    = sr;
    wok = we && (q.size() < DEPTH);
    rok = re && (q.size() > 0);
    if (sr) begin
      model_clear();
    end else begin
      m_done = 1'b0;
      if (rok) begin
        e = q.pop_front();
        m_dout = e[7:0];
        if (e[8]) begin
          m_rem = int'(e[7:2]) + 1;
        end else if (m_rem > 0) begin
          m_rem--;
          m_done = (m_rem == 0);
        end
      end
      if (wok) q.push_back({lfd, din});
    end
    @(posedge clock);
    #1;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.lfd_state = 1'b0;
    soft_reset    = 1'b0;
    check_model(tag);
  endtask

  task automatic wr(input logic lfd, input logic [7:0] d, input string tag);
    cycle(1'b1, lfd, d, 1'b0, 1'b0, tag);
  endtask

  task automatic rd(input string tag);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, tag);
  endtask

  logic [7:0] pkt1 [5];

  initial begin
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = 8'h00;
    bus.read_enb  = 1'b0;
    pkt1[0] = 8'h0D; pkt1[1] = 8'hA1; pkt1[2] = 8'hA2;
    pkt1[3] = 8'hA3; pkt1[4] = 8'h5F;

    #1;
    check_model("reset");
    #11 resetn = 1'b1;
    @(posedge clock);
    #1;
    check_model("post_reset");

    // Single packet, header len 3
    for (int i = 0; i < 5; i++) wr(i == 0, pkt1[i], "pkt1_wr");
    for (int i = 0; i < 5; i++) begin
      rd("pkt1_rd");
      check("pkt1_seq", 32'(bus.data_out), 32'(pkt1[i]));
      if (i == 0) check("pkt1_active", 32'(bus.pkt_active), 32'd1);
      if (i == 4) check("pkt1_done", 32'(bus.pkt_done), 32'd1);
    end
    check("pkt1_empty", 32'(bus.empty), 32'd1);

    // Fill to full, overflow dropped
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(i), "fill_wr");
    check("full_flag", 32'(bus.full), 32'd1);
    check("full_fill", 32'(bus.fill), 32'd16);
    wr(1'b0, 8'hFF, "ovf_wr");
    check("ovf_fill", 32'(bus.fill), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd("drain_rd");
      check("drain_seq", 32'(bus.data_out), 32'(i));
    end

    // Full with simultaneous read and write
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h40 + i), "frw_wr");
    cycle(1'b1, 1'b0, 8'h77, 1'b1, 1'b0, "frw_both1");
    check("frw_fill1", 32'(bus.fill), 32'd15);
    cycle(1'b1, 1'b0, 8'h77, 1'b1, 1'b0, "frw_both2");
    check("frw_fill2", 32'(bus.fill), 32'd15);
    for (int i = 0; i < 15; i++) rd("frw_rd");
    check("frw_77_15th", 32'(bus.data_out), 32'h77);

    // Empty with simultaneous read and write
    cycle(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, "erw_both");
    check("erw_fill", 32'(bus.fill), 32'd1);
    check("erw_dout_hold", 32'(bus.data_out), 32'h77);
    rd("erw_rd");
    check("erw_dout", 32'(bus.data_out), 32'h3C);

    // Steady occupancy of 3 across pointer wrap
    for (int i = 0; i < 3; i++) wr(1'b0, 8'($urandom), "wrap_pre");
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0, "wrap_rw");
      check("wrap_fill", 32'(bus.fill), 32'd3);
    end
    for (int i = 0; i < 3; i++) rd("wrap_drain");

    // Random traffic, headers and occasional flush
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0),
            8'($urandom),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 49) == 0),
            "rand");
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "rand_flush");

    // Mid-packet soft reset
    wr(1'b1, 8'h14, "flush_wr");
    for (int i = 0; i < 6; i++) wr(1'b0, 8'(8'hB0 + i), "flush_wr");
    for (int i = 0; i < 3; i++) rd("flush_rd");
    check("flush_pre_active", 32'(bus.pkt_active), 32'd1);
    cycle(1'b1, 1'b0, 8'hEE, 1'b1, 1'b1, "flush_sr");
    check("flush_empty", 32'(bus.empty), 32'd1);
    check("flush_active", 32'(bus.pkt_active), 32'd0);
    check("flush_dout", 32'(bus.data_out), 32'd0);
    check("flush_done", 32'(bus.pkt_done), 32'd0);

    // Asynchronous reset in the middle of a write burst
    for (int i = 0; i < 4; i++) wr(i == 0, 8'(8'h0C + i), "async_wr");
    rd("async_rd");
    bus.write_enb = 1'b1;
    bus.data_in   = 8'h99;
    #3 resetn = 1'b0;
    #1;
    model_clear();
    check_model("async_rst");
    bus.write_enb = 1'b0;
    @(posedge clock);
    #2 resetn = 1'b1;
    @(posedge clock);
    #1;
    check_model("async_rel");
    rd("async_rd_empty");
    check("async_no_fire", 32'(bus.data_out), 32'd0);
    wr(1'b0, 8'h5A, "async_wr2");
    rd("async_rd2");
    check("async_first", 32'(bus.data_out), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
